svm_seq_ctrl: RTL

Sequencer that configures and feeds the 6-SV polynomial SVM classifier core (`svm`). It collects a weight set and alpha over a valid/ready config port. It then programs the core with the start pulse followed by one weight per cycle. After that it streams (x,y) samples into the core with valid/ready and returns one label per sample. It sits between the host/stream fabric and the core, and drains in-flight samples before any reconfiguration.

---
 rtl/svm_seq_ctrl_if.sv | 46 ++++
 rtl/svm_seq_ctrl.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/svm_seq_ctrl_if.sv
// Bundle of the host config port, the sample/label stream and the core-facing
// programming/data signals around the SVM sequencer. The slave modport is the
// sequencer's view; the master modport is the environment (host fabric plus core).
interface svm_seq_ctrl_if #(
    parameter int alpha_BW  = 16,
    parameter int weight_BW = 16,
    parameter int data_BW   = 16
);
    logic                 cfg_valid;
    logic                 cfg_ready;
    logic [weight_BW-1:0] cfg_weight;
    logic [alpha_BW-1:0]  cfg_alpha;
    logic                 smp_valid;
    logic                 smp_ready;
    logic [data_BW-1:0]   smp_x;
    logic [data_BW-1:0]   smp_y;
    logic                 lbl_valid;
    logic                 lbl;
    logic                 core_start;
    logic [alpha_BW-1:0]  core_alpha;
    logic [weight_BW-1:0] core_weight;
    logic                 core_DE_in;
    logic [data_BW-1:0]   core_data_x;
    logic [data_BW-1:0]   core_data_y;
    logic                 core_DE_out;
    logic                 core_label;
    logic                 busy;

    modport slave (
        input  cfg_valid, cfg_weight, cfg_alpha,
        input  smp_valid, smp_x, smp_y,
        input  core_DE_out, core_label,
        output cfg_ready, smp_ready, lbl_valid, lbl,
        output core_start, core_alpha, core_weight, core_DE_in,
        output core_data_x, core_data_y, busy
    );

    modport master (
        output cfg_valid, cfg_weight, cfg_alpha,
        output smp_valid, smp_x, smp_y,
        output core_DE_out, core_label,
        input  cfg_ready, smp_ready, lbl_valid, lbl,
        input  core_start, core_alpha, core_weight, core_DE_in,
        input  core_data_x, core_data_y, busy
    );
endinterface

// File: rtl/svm_seq_ctrl.sv
// Sequencer for the polynomial SVM core: gathers a weight set and alpha from
// the host, programs the core (start pulse, alpha, one weight per cycle), then
// streams samples into the core and forwards its labels. Any reconfiguration
// request first drains the samples still inside the core.
module svm_seq_ctrl #(
    parameter int nSVs      = 6,
    parameter int alpha_BW  = 16,
    parameter int weight_BW = 16,
    parameter int data_BW   = 16,
    parameter int CNT_W     = 4
) (
    input  logic           clk,
    input  logic           reset,
    svm_seq_ctrl_if.slave  bus
);
    localparam int IDX_W = (nSVs > 1) ? $clog2(nSVs) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(nSVs - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_KICK  = 3'd2,
        S_SYNC  = 3'd3,
        S_PROG  = 3'd4,
        S_RUN   = 3'd5,
        S_DRAIN = 3'd6
    } state_t;

    state_t               state_r;
    logic [IDX_W-1:0]     idx_r;
    logic [weight_BW-1:0] wbuf_r [nSVs];
    logic [alpha_BW-1:0]  alpha_r;
    logic [CNT_W-1:0]     outstanding_r;

    logic                 core_start_r;
    logic [alpha_BW-1:0]  core_alpha_r;
    logic [weight_BW-1:0] core_weight_r;
    logic                 core_de_in_r;
    logic [data_BW-1:0]   core_data_x_r;
    logic [data_BW-1:0]   core_data_y_r;
    logic                 lbl_valid_r;
    logic                 lbl_r;

    logic                 cfg_ready_s;
    logic                 smp_ready_s;
    logic                 cfg_hs_s;
    logic                 smp_hs_s;

    // Ready decodes come straight from the state register; sample ready also
    // yields immediately to a pending config request so no new sample slips in.
    assign cfg_ready_s = (state_r == S_LOAD);
    assign smp_ready_s = (state_r == S_RUN) && !bus.cfg_valid;
    assign cfg_hs_s    = cfg_ready_s && bus.cfg_valid;
    assign smp_hs_s    = smp_ready_s && bus.smp_valid;

    assign bus.cfg_ready   = cfg_ready_s;
    assign bus.smp_ready   = smp_ready_s;
    assign bus.busy        = (state_r != S_IDLE) && (state_r != S_RUN);
    assign bus.core_start  = core_start_r;
    assign bus.core_alpha  = core_alpha_r;
    assign bus.core_weight = core_weight_r;
    assign bus.core_DE_in  = core_de_in_r;
    assign bus.core_data_x = core_data_x_r;
    assign bus.core_data_y = core_data_y_r;
    assign bus.lbl_valid   = lbl_valid_r;
    assign bus.lbl         = lbl_r;

    // Weight buffer: written in index order on each config handshake; its
    // contents are irrelevant until a full set has been loaded, so no reset.
    always_ff @(posedge clk) begin
        if (cfg_hs_s) begin
            wbuf_r[idx_r] <= bus.cfg_weight;
        end
    end

    // Main sequencer FSM with its registered core-facing outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r       <= S_IDLE;
            idx_r         <= {IDX_W{1'b0}};
            alpha_r       <= {alpha_BW{1'b0}};
            core_start_r  <= 1'b0;
            core_alpha_r  <= {alpha_BW{1'b0}};
            core_weight_r <= {weight_BW{1'b0}};
            core_de_in_r  <= 1'b0;
            core_data_x_r <= {data_BW{1'b0}};
            core_data_y_r <= {data_BW{1'b0}};
        end else begin
            core_start_r <= 1'b0;
            core_de_in_r <= 1'b0;
            case (state_r)
                S_IDLE: begin
                    if (bus.cfg_valid) begin
                        state_r <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (cfg_hs_s) begin
                        if (idx_r == {IDX_W{1'b0}}) begin
                            alpha_r <= bus.cfg_alpha;
                        end
                        if (idx_r == IDX_LAST) begin
                            idx_r        <= {IDX_W{1'b0}};
                            core_start_r <= 1'b1;
                            state_r      <= S_KICK;
                        end else begin
                            idx_r <= idx_r + IDX_W'(1);
                        end
                    end
                end
                S_KICK: begin
                    // alpha becomes visible in SYNC and stays put until the next KICK
                    core_alpha_r <= alpha_r;
                    state_r      <= S_SYNC;
                end
                S_SYNC: begin
                    idx_r         <= {IDX_W{1'b0}};
                    core_weight_r <= wbuf_r[0];
                    state_r       <= S_PROG;
                end
                S_PROG: begin
                    if (idx_r == IDX_LAST) begin
                        idx_r         <= {IDX_W{1'b0}};
                        core_weight_r <= {weight_BW{1'b0}};
                        state_r       <= S_RUN;
                    end else begin
                        idx_r         <= idx_r + IDX_W'(1);
                        core_weight_r <= wbuf_r[idx_r + IDX_W'(1)];
                    end
                end
                S_RUN: begin
                    if (smp_hs_s) begin
                        core_data_x_r <= bus.smp_x;
                        core_data_y_r <= bus.smp_y;
                        core_de_in_r  <= 1'b1;
                    end
                    if (bus.cfg_valid) begin
                        state_r <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (outstanding_r == {CNT_W{1'b0}}) begin
                        state_r <= S_LOAD;
                    end
                end
                default: begin
                    state_r <= S_IDLE;
                end
            endcase
        end
    end

    // Samples inside the core: up on acceptance, down on each core result,
    // saturating at zero against a stray result.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            outstanding_r <= {CNT_W{1'b0}};
        end else begin
            case ({smp_hs_s, bus.core_DE_out})
                2'b10: outstanding_r <= outstanding_r + CNT_W'(1);
                2'b01: begin
                    if (outstanding_r != {CNT_W{1'b0}}) begin
                        outstanding_r <= outstanding_r - CNT_W'(1);
                    end else begin
                        outstanding_r <= {CNT_W{1'b0}};
                    end
                end
                default: outstanding_r <= outstanding_r;
            endcase
        end
    end

    // Label return path: one register stage behind the core outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lbl_valid_r <= 1'b0;
            lbl_r       <= 1'b0;
        end else begin
            lbl_valid_r <= bus.core_DE_out;
            lbl_r       <= bus.core_label;
        end
    end
endmodule
